round_robin_arbiter_4: RTL
==========================

ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, max consecutive grant cycles per owner (legal 2..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: en  input  1  arbitration enable; 0 blocks new grants.
REQ-005 SHALL have port: req  input  4  request per requester, level, bit i = requester i.
REQ-006 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-007 SHALL have port: gnt_id  output  2  binary index of current owner, valid only while gnt_valid=1.
REQ-008 SHALL have port: gnt_valid  output  1  1 while any grant is held.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse when a grant is revoked at MAX_HOLD.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one owner).
REQ-011 In IDLE with en=1 and req!=0, SHALL select the first requesting bit scanning upward from (last+1) mod 4, wrapping 3->0, and enter GRANT at the next edge.
REQ-012 Grant latency SHALL be exactly 1 cycle: req sampled at edge N, gnt asserted after edge N+1.
REQ-013 In IDLE with en=0 or req=0, SHALL stay in IDLE with gnt=4'b0000.
REQ-014 gnt SHALL always be 4'b0000 or exactly one-hot, equal to the decode of gnt_id gated by gnt_valid.
REQ-015 In GRANT, SHALL hold the grant while req[gnt_id]=1 and hold count < MAX_HOLD; en=0 does not revoke a held grant.
REQ-016 When req[gnt_id]=0 is sampled in GRANT, SHALL return to IDLE at that edge (gnt=0 for at least one cycle) and set last=gnt_id.
REQ-017 Hold counter SHALL load 1 on entry to GRANT and increment each GRANT cycle; when it equals MAX_HOLD with req[gnt_id] still 1, SHALL revoke (enter IDLE), set last=gnt_id, and pulse timeout for exactly the first IDLE cycle.
REQ-018 Release and timeout sampled on the same edge SHALL be treated as release (no timeout pulse).
REQ-019 A timed-out owner SHALL NOT be masked; it competes in the next arbitration from last+1 and regains the grant only if no other bit is set.
REQ-020 Changes of non-owner req bits during GRANT SHALL have no effect on the current grant.
REQ-021 Maximum grant-to-grant gap for any continuously requesting requester SHALL be 3*(MAX_HOLD+1) cycles (fairness bound).

Reset
REQ-022 rst_n=0 sampled at a rising edge SHALL force: state IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, hold count 0, last=2'b11 (requester 0 has first priority).
REQ-023 Reset asserted mid-GRANT SHALL drop the grant at that same edge with no timeout pulse; arbitration resumes at the first edge with rst_n=1.

Structure
REQ-024 State encoding (IDLE, GRANT) and the default MAX_HOLD SHALL live in a shared package arb_pkg.
REQ-025 The one-hot gnt output SHALL be produced by one instance of the team's existing 2-to-4 decoder block (gnt_id as select, gnt_valid as enable); no other sub-modules.
REQ-026 Hold counter width SHALL be 8 bits.

Verification
REQ-027 Reset then req=4'b1111, en=1 held -> grants in order 0,1,2,3,0 each lasting MAX_HOLD=8 cycles, timeout pulse after each, 1-cycle gnt=0 gap between.
REQ-028 req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100 from cycle 2 for 3 cycles, gnt=0 next cycle, no timeout.
REQ-029 Only req[1] held 20 cycles -> gnt=4'b0010 for 8, gap 1, timeout=1 in gap, regranted to 1, repeat.
REQ-030 Owner 2 granted, en driven 0 -> grant held until req[2]=0; afterwards no grant while en=0 despite req=4'b1011.
REQ-031 rst_n=0 for 1 cycle during grant to 3 with req=4'b1001 -> gnt=0, timeout=0; after release, grant goes to 0 (last reset to 3).
REQ-032 Every cycle of every test: gnt is zero or one-hot and equals decode(gnt_id) when gnt_valid=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// default hold limit and the rotating-priority pick function.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_HOLD_DEFAULT = 8;
    localparam logic [1:0]  LAST_RESET       = 2'b11;

    // First set request bit scanning upward from last+1, wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + i[1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

endpackage

// File: rtl/round_robin_arbiter_4_dec.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module round_robin_arbiter_4_dec (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] dec
);

    // Enable-gated one-hot decode of sel.
    always_comb begin
        dec = 4'b0000;
        if (en) begin
            case (sel)
                2'd0:    dec = 4'b0001;
                2'd1:    dec = 4'b0010;
                2'd2:    dec = 4'b0100;
                2'd3:    dec = 4'b1000;
                default: dec = 4'b0000;
            endcase
        end else begin
            dec = 4'b0000;
        end
    end

endmodule

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with a per-owner hold limit; an owner
// kept for MAX_HOLD cycles is revoked and a one-cycle timeout pulse follows.
module round_robin_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    arb_state_e state_r;
    logic [7:0] hold_cnt_r;
    logic [1:0] last_r;
    logic [1:0] pick_s;

    assign pick_s = rr_pick(req, last_r);

    // Arbitration FSM; all outputs except gnt are registered here directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_id     <= 2'b00;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
            hold_cnt_r <= 8'd0;
            last_r     <= LAST_RESET;
        end else begin
            timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en && (req != 4'b0000)) begin
                        state_r    <= ST_GRANT;
                        gnt_id     <= pick_s;
                        gnt_valid  <= 1'b1;
                        hold_cnt_r <= 8'd1;
                    end else begin
                        state_r    <= ST_IDLE;
                        gnt_valid  <= 1'b0;
                        hold_cnt_r <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    // Release wins over a coincident hold-limit expiry.
                    if (!req[gnt_id]) begin
                        state_r    <= ST_IDLE;
                        gnt_valid  <= 1'b0;
                        hold_cnt_r <= 8'd0;
                        last_r     <= gnt_id;
                    end else if (hold_cnt_r == MAX_HOLD[7:0]) begin
                        state_r    <= ST_IDLE;
                        gnt_valid  <= 1'b0;
                        hold_cnt_r <= 8'd0;
                        last_r     <= gnt_id;
                        timeout    <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    gnt_valid  <= 1'b0;
                    hold_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    round_robin_arbiter_4_dec u_dec (
        .sel (gnt_id),
        .en  (gnt_valid),
        .dec (gnt)
    );

endmodule
